mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 Parameter: W, default 32, operand and result word width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a multiply; sampled on each rising edge.
REQ-005 Port: signed_op  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with start.
REQ-006 Port: a  input  W  multiplicand; sampled with start.
REQ-007 Port: b  input  W  multiplier; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; results valid from that cycle onward.
REQ-010 Port: r  output  W  low word of the product.
REQ-011 Port: hi  output  W  high word of the 2W-bit product.
REQ-012 Port: n, z, c, v  output  1 each  negative, zero, carry/unsigned overflow, signed overflow flags.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-014 In IDLE, start=1 SHALL latch a, b and signed_op, clear the accumulator, load the counter with W, and enter RUN.
REQ-015 In RUN, each cycle SHALL perform one shift-add step on operand magnitudes and decrement the counter; at count 1 the next state SHALL be FIN.
REQ-016 In FIN, the block SHALL register r, hi and the flags, pulse done for one cycle, and return to IDLE.
REQ-017 Latency: start accepted at edge k -> busy=1 from edge k+1 through edge k+W; done=1 and results valid after edge k+W+1.
REQ-018 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored; latched operands SHALL be unaffected.
REQ-020 start in the same cycle that done=1 SHALL not be accepted; the earliest accept is the cycle after done.
REQ-021 Signed op: operands SHALL be converted to magnitude; the 2W-bit result SHALL be negated when the sign bits differ; the most negative value SHALL multiply correctly (e.g. W=8: -128 * -1 = +128 in 16 bits).
REQ-022 {hi, r} SHALL equal the exact 2W-bit product (signed or unsigned, per signed_op).
REQ-023 n = r[W-1]; z = (r == 0) on the low word only.
REQ-024 Unsigned op: c = (hi != 0), v = 0.
REQ-025 Signed op: c = 0, v = (hi != W copies of r[W-1]).
REQ-026 r, hi and the flags SHALL hold their values until the next FIN; they SHALL not change during RUN.
REQ-027 A zero operand SHALL still take the full W-cycle latency; there SHALL be no early termination.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE and clear busy, done, r, hi, n, z, c and v to 0, aborting any operation in progress.
REQ-029 rst SHALL take priority over start in the same cycle; no operation SHALL be accepted while rst=1.
REQ-030 The first start can be accepted at the first edge with rst=0.

Structure
REQ-031 A shared package mul_pkg SHALL hold the state enum (IDLE, RUN, FIN) and the default width constant MUL_W_DEFAULT = 32.
REQ-032 The counter width SHALL be ceil(log2(W+1)), derived in the module.
REQ-033 The block SHALL be a single module with no sub-modules; the datapath is one W-bit adder plus a 2W-bit shift register.

Verification
REQ-034 W=32, unsigned, a=0x0001_0000, b=0x0001_0000 -> done 33 cycles after start; hi=1, r=0, z=1, c=1, v=0, n=0.
REQ-035 W=8, signed, a=0x80 (-128), b=0xFF (-1) -> {hi,r}=0x0080; r=0x80, n=1, v=1, c=0, z=0.
REQ-036 W=8, signed, a=0xFD (-3), b=0x05 -> {hi,r}=0xFFF1; r=0xF1, n=1, v=0, z=0.
REQ-037 W=32, start pulsed again at cycles 5 and 20 of a running operation -> ignored; a single done and the result of the first operands only.
REQ-038 W=32, rst asserted at cycle 10 of RUN -> next cycle busy=0, all outputs 0; a new start after rst falls completes normally with 33-cycle latency.
REQ-039 Randomised 10k-vector sweep at W=8 and W=32, both modes, with back-to-back starts -> {hi,r} and the flags match the reference model on every done.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_pkg;

  localparam int MUL_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative W-cycle shift-add multiplier, signed or unsigned, with a full
// 2W-bit product and NZCV-style flags.
module mul_iter
  import mul_pkg::*;
#(
  parameter int W = MUL_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r,
  output logic [W-1:0] hi,
  output logic         n,
  output logic         z,
  output logic         c,
  output logic         v
);

  localparam int CW = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    hi_q, hi_d;
  logic            n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic            done_q, done_d;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum;
  logic [2*W-1:0]  res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    r_d     = r_q;
    hi_d    = hi_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;

    a_neg = signed_op & a[W-1];
    b_neg = signed_op & b[W-1];
    // Negating the most negative value yields 2^(W-1) as an unsigned magnitude
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    res = neg_q ? -prod_q : prod_q;

    case (state_q)
      IDLE: begin
        // The cycle carrying done is never an accept cycle
        if (start && !done_q) begin
          mcand_d = a_mag;
          prod_d  = {{W{1'b0}}, b_mag};
          neg_d   = a_neg ^ b_neg;
          sgn_d   = signed_op;
          cnt_d   = CW'(W);
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = {sum, prod_q[W-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        r_d     = res[W-1:0];
        hi_d    = res[2*W-1:W];
        n_d     = res[W-1];
        z_d     = (res[W-1:0] == '0);
        c_d     = !sgn_q && (res[2*W-1:W] != '0);
        v_d     = sgn_q && (res[2*W-1:W] != {W{res[W-1]}});
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      r_q     <= '0;
      hi_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      r_q     <= r_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign r    = r_q;
  assign hi   = hi_q;
  assign n    = n_q;
  assign z    = z_q;
  assign c    = c_q;
  assign v    = v_q;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter at W=8 and W=32: directed vectors, control
// corner cases and a short back-to-back random sweep against a reference product.
module tb_mul_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, r8, hi8;
  logic        busy8, done8, n8, z8, c8, v8;
  logic        start32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, r32, hi32;
  logic        busy32, done32, n32, z32, c32, v32;

  mul_iter #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_op(sg8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .r(r8), .hi(hi8),
    .n(n8), .z(z8), .c(c8), .v(v8)
  );

  mul_iter #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_op(sg32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .r(r32), .hi(hi32),
    .n(n32), .z(z32), .c(c32), .v(v32)
  );

  typedef struct {
    logic [63:0] hi;
    logic [63:0] r;
    logic [3:0]  f;
    int          due;
    int          id;
  } exp_t;

  typedef struct {
    bit          sg;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] r;
    logic [3:0]  f;
  } vec_t;

  // Hand-computed products; f = {n, z, c, v}
  vec_t vecs8 [8] = '{
    '{1'b1, 64'h80, 64'hFF, 64'h00, 64'h80, 4'b1001},
    '{1'b1, 64'hFD, 64'h05, 64'hFF, 64'hF1, 4'b1000},
    '{1'b0, 64'hFF, 64'hFF, 64'hFE, 64'h01, 4'b0010},
    '{1'b0, 64'h10, 64'h10, 64'h01, 64'h00, 4'b0110},
    '{1'b1, 64'h80, 64'h80, 64'h40, 64'h00, 4'b0101},
    '{1'b1, 64'h7F, 64'h81, 64'hC0, 64'hFF, 4'b1001},
    '{1'b0, 64'h00, 64'hAB, 64'h00, 64'h00, 4'b0100},
    '{1'b1, 64'h0C, 64'hF6, 64'hFF, 64'h88, 4'b1000}
  };

  vec_t vecs32 [8] = '{
    '{1'b0, 64'h0001_0000, 64'h0001_0000, 64'h0000_0001, 64'h0000_0000, 4'b0110},
    '{1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 64'h0000_0001, 4'b0010},
    '{1'b0, 64'h0000_0000, 64'h1234_5678, 64'h0000_0000, 64'h0000_0000, 4'b0100},
    '{1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0000, 64'h0000_0001, 4'b0000},
    '{1'b1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 64'h0000_0000, 4'b0101},
    '{1'b1, 64'hFFFF_FFFD, 64'h0000_0005, 64'hFFFF_FFFF, 64'hFFFF_FFF1, 4'b1000},
    '{1'b0, 64'h0000_04D2, 64'h0000_162E, 64'h0000_0000, 64'h006A_E9BC, 4'b0000},
    '{1'b1, 64'h7FFF_FFFF, 64'h0000_0002, 64'h0000_0000, 64'hFFFF_FFFE, 4'b1001}
  };

  exp_t q8 [$];
  exp_t q32 [$];
  exp_t e8, e32;
  int   cyc = 0;
  int   nid = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Monitor: every done pops one expected result and compares it
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("w8 unexpected done", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        chk($sformatf("w8 #%0d hi", e8.id), {56'd0, hi8}, e8.hi);
        chk($sformatf("w8 #%0d r", e8.id), {56'd0, r8}, e8.r);
        chk($sformatf("w8 #%0d nzcv", e8.id), {60'd0, n8, z8, c8, v8}, {60'd0, e8.f});
        chk($sformatf("w8 #%0d latency", e8.id), 64'(cyc), 64'(e8.due));
        $display("w8  #%0d hi=%h r=%h nzcv=%b", e8.id, hi8, r8, {n8, z8, c8, v8});
      end
    end
    if (done32) begin
      if (q32.size() == 0) begin
        chk("w32 unexpected done", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        chk($sformatf("w32 #%0d hi", e32.id), {32'd0, hi32}, e32.hi);
        chk($sformatf("w32 #%0d r", e32.id), {32'd0, r32}, e32.r);
        chk($sformatf("w32 #%0d nzcv", e32.id), {60'd0, n32, z32, c32, v32}, {60'd0, e32.f});
        chk($sformatf("w32 #%0d latency", e32.id), 64'(cyc), 64'(e32.due));
        $display("w32 #%0d hi=%h r=%h nzcv=%b", e32.id, hi32, r32, {n32, z32, c32, v32});
      end
    end
  end

  function automatic void ref_mul(input int w, input bit sg, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] hi,
                                  output logic [63:0] r, output logic [3:0] f);
    logic [63:0]  mw;
    logic [127:0] ax, bx, p;
    mw = (64'd1 << w) - 64'd1;
    ax = {64'd0, a & mw};
    bx = {64'd0, b & mw};
    if (sg && a[w-1]) ax = ax | ~{64'd0, mw};
    if (sg && b[w-1]) bx = bx | ~{64'd0, mw};
    p  = ax * bx;
    r  = p[63:0] & mw;
    hi = 64'(p >> w) & mw;
    f[3] = r[w-1];
    f[2] = (r == 64'd0);
    f[1] = !sg && (hi != 64'd0);
    f[0] = sg && (hi != (r[w-1] ? mw : 64'd0));
  endfunction

  task automatic wait_idle(input bit w32);
    for (int i = 0; i < 200; i++) begin
      if ((w32 ? q32.size() : q8.size()) == 0) return;
      @(negedge clk);
    end
    chk(w32 ? "w32 done timeout" : "w8 done timeout", 64'd1, 64'd0);
    if (w32) q32.delete();
    else q8.delete();
  endtask

  task automatic issue(input bit w32, input bit sg, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ehi, input logic [63:0] er, input logic [3:0] f,
                       input bit wait_done);
    exp_t e;
    @(negedge clk);
    e.hi = ehi;
    e.r  = er;
    e.f  = f;
    e.id = nid++;
    e.due = cyc + (w32 ? 34 : 10);
    if (w32) begin
      start32 = 1'b1; sg32 = sg; a32 = a[31:0]; b32 = b[31:0];
      q32.push_back(e);
    end else begin
      start8 = 1'b1; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
      q8.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
    if (wait_done) wait_idle(w32);
  endtask

  task automatic rand_run(input bit w32, input int count);
    logic [63:0] a, b, ehi, er;
    logic [3:0]  f;
    bit          sg;
    for (int i = 0; i < count; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      sg = 1'($urandom_range(0, 1));
      ref_mul(w32 ? 32 : 8, sg, a, b, ehi, er, f);
      issue(w32, sg, a, b, ehi, er, f, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("w8 reset outputs", {46'd0, busy8, done8, hi8, r8, n8, z8, c8, v8}, 64'd0);
    chk("w32 reset outputs", {busy32 | done32 | n32 | z32 | c32 | v32, hi32[30:0], r32}, 64'd0);
    rst = 1'b0;

    foreach (vecs8[i])
      issue(1'b0, vecs8[i].sg, vecs8[i].a, vecs8[i].b, vecs8[i].hi, vecs8[i].r, vecs8[i].f, 1'b1);
    foreach (vecs32[i])
      issue(1'b1, vecs32[i].sg, vecs32[i].a, vecs32[i].b, vecs32[i].hi, vecs32[i].r, vecs32[i].f, 1'b1);

    // Restarts mid-run are ignored; previous result holds during RUN
    issue(1'b1, 1'b0, 64'h0001_0000, 64'h0001_0000, 64'h1, 64'h0, 4'b0110, 1'b0);
    repeat (4) @(negedge clk);
    start32 = 1'b1; sg32 = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
    chk("w32 busy during run", {63'd0, busy32}, 64'd1);
    chk("w32 result held in run", {hi32, r32}, 64'h0000_0000_FFFF_FFFE);
    @(negedge clk);
    start32 = 1'b0;
    repeat (14) @(negedge clk);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_idle(1'b1);
    repeat (3) @(negedge clk);
    chk("w32 idle after done", {63'd0, busy32}, 64'd0);

    // A start coinciding with done is not accepted
    issue(1'b0, 1'b0, 64'h10, 64'h10, 64'h01, 64'h00, 4'b0110, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (done8) break;
      @(negedge clk);
    end
    start8 = 1'b1; sg8 = 1'b0; a8 = 8'h03; b8 = 8'h03;
    @(negedge clk);
    start8 = 1'b0;
    chk("w8 start during done ignored", {63'd0, busy8}, 64'd0);
    repeat (12) @(negedge clk);

    // Reset in mid-run aborts the operation and wins over a simultaneous start
    issue(1'b1, 1'b0, 64'h3, 64'h5, 64'h0, 64'hF, 4'b0000, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start32 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start32 = 1'b0;
    q32.delete();
    chk("w32 outputs after abort", {busy32 | done32 | n32 | z32 | c32 | v32, hi32[30:0], r32}, 64'd0);
    chk("w32 hi msb after abort", {63'd0, hi32[31]}, 64'd0);
    @(negedge clk);
    chk("w32 rst beats start", {63'd0, busy32}, 64'd0);
    issue(1'b1, 1'b1, 64'hFFFF_FFFD, 64'h5, 64'hFFFF_FFFF, 64'hFFFF_FFF1, 4'b1000, 1'b1);

    rand_run(1'b0, 100);
    rand_run(1'b1, 100);

    repeat (5) @(negedge clk);
    chk("w8 queue drained", 64'(q8.size()), 64'd0);
    chk("w32 queue drained", 64'(q32.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
